// File: rtl/output_queue.sv
// output_queue: playback-side circular FIFO for real IFFT samples.
// Releases one sample every SAMPLE_DIV cycles and drives it out as a PWM duty cycle.
module output_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int DEPTH      = 2048,
  parameter int PWM_BITS   = 8,
  parameter int SAMPLE_DIV = 2048
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2*DATA_WIDTH-1:0] s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    aud_pwm,
  output logic                    aud_sd,
  output logic                    underflow,
  output logic                    frame_error
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CNT_W-1:0]    FULL_C      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]    FRAME_C     = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]    EMPTY_C     = {CNT_W{1'b0}};
  localparam logic [BEAT_W-1:0]   LAST_BEAT_C = BEAT_W'(FRAME_LEN - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST_C  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ZERO_C  = {DIV_W{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_ZERO_C  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] MID_C       = {1'b1, {(PWM_BITS-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  // Signed sample top bits -> offset binary: flipping the sign bit adds half scale.
  function automatic logic [PWM_BITS-1:0] to_duty(input logic [PWM_BITS-1:0] top);
    to_duty = {~top[PWM_BITS-1], top[PWM_BITS-2:0]};
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
  state_t                state_q, state_d;
  logic                  aud_pwm_q, aud_pwm_d, aud_sd_q, aud_sd_d;
  logic                  underflow_q, frame_error_q, frame_error_d;

  logic                  push_s, tick_s, pop_s, underflow_s;
  logic [DATA_WIDTH-1:0] rd_sample_s;
  logic                  unused_imag_s, unused_low_s;

  // Ready depends only on registered occupancy, never on s_tvalid.
  assign s_tready    = (count_q != FULL_C) && !reset;
  assign push_s      = s_tvalid && s_tready;
  assign tick_s      = (state_q == PLAY) && (div_q == DIV_ZERO_C);
  assign pop_s       = tick_s && (count_q != EMPTY_C);
  assign underflow_s = tick_s && (count_q == EMPTY_C);
  assign rd_sample_s = mem_q[rd_ptr_q];

  // Only the top PWM_BITS of the real part and nothing of the imaginary part reach the pin.
  assign unused_imag_s = ^s_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign unused_low_s  = ^rd_sample_s[DATA_WIDTH-PWM_BITS-1:0];

  assign aud_pwm     = aud_pwm_q;
  assign aud_sd      = aud_sd_q;
  assign underflow   = underflow_q;
  assign frame_error = frame_error_q;

  // FIFO bookkeeping: pointers, occupancy and frame-boundary tracking.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    beat_d        = beat_q;
    frame_error_d = 1'b0;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_s) begin
      // Any frame boundary (real or forced) restarts the beat count; a mismatch flags an error.
      frame_error_d = s_tlast ^ (beat_q == LAST_BEAT_C);
      if (s_tlast || (beat_q == LAST_BEAT_C)) begin
        beat_d = {BEAT_W{1'b0}};
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // Playback FSM: sample divider, PWM counter and duty reload on each tick.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    case (state_q)
      IDLE: begin
        div_d     = DIV_ZERO_C;
        pwm_cnt_d = PWM_ZERO_C;
        if (count_d >= FRAME_C) begin
          state_d = PLAY;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        div_d     = (div_q == DIV_LAST_C) ? DIV_ZERO_C : div_q + DIV_W'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        if (pop_s) begin
          duty_d = to_duty(rd_sample_s[DATA_WIDTH-1 -: PWM_BITS]);
        end else if (underflow_s) begin
          state_d   = IDLE;
          duty_d    = MID_C;
          div_d     = DIV_ZERO_C;
          pwm_cnt_d = PWM_ZERO_C;
        end else begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d   = IDLE;
        div_d     = DIV_ZERO_C;
        pwm_cnt_d = PWM_ZERO_C;
        duty_d    = MID_C;
      end
    endcase
    // The pin is forced low on the cycle playback stops so it drops together with aud_sd.
    aud_sd_d  = (state_d == PLAY);
    aud_pwm_d = (state_q == PLAY) && (state_d == PLAY) && (pwm_cnt_q < duty_q);
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= EMPTY_C;
      beat_q        <= {BEAT_W{1'b0}};
      div_q         <= DIV_ZERO_C;
      pwm_cnt_q     <= PWM_ZERO_C;
      duty_q        <= MID_C;
      state_q       <= IDLE;
      aud_pwm_q     <= 1'b0;
      aud_sd_q      <= 1'b0;
      underflow_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      beat_q        <= beat_d;
      div_q         <= div_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      state_q       <= state_d;
      aud_pwm_q     <= aud_pwm_d;
      aud_sd_q      <= aud_sd_d;
      underflow_q   <= underflow_s;
      frame_error_q <= frame_error_d;
    end
  end

  // Sample storage; contents are don't-care after reset since count governs validity.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s_tdata[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_output_queue.sv
// tb_output_queue: randomized scoreboard bench for output_queue.
module tb_output_queue;

  localparam int DATA_WIDTH   = 16;
  localparam int FRAME_LEN    = 16;
  localparam int DEPTH        = 32;
  localparam int PWM_BITS     = 8;
  localparam int SAMPLE_DIV   = 512;
  localparam int PWM_PERIOD   = 1 << PWM_BITS;
  localparam int BEAT_TIMEOUT = 2 * SAMPLE_DIV + 16;

  logic                    clock;
  logic                    reset;
  logic [2*DATA_WIDTH-1:0] s_tdata;
  logic                    s_tvalid;
  logic                    s_tlast;
  logic                    s_tready;
  logic                    aud_pwm;
  logic                    aud_sd;
  logic                    underflow;
  logic                    frame_error;

  output_queue #(
    .DATA_WIDTH(DATA_WIDTH), .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH),
    .PWM_BITS(PWM_BITS), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clock(clock), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .aud_pwm(aud_pwm), .aud_sd(aud_sd),
    .underflow(underflow), .frame_error(frame_error)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_q[$];      // expected duty of every accepted sample, in play order
  logic fe_q[$];       // expected frame_error for every accepted beat
  int   model_beat = 0;
  bit   mon_active = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference duty: signed sample scaled to PWM_BITS, then shifted up by half scale.
  function automatic int exp_duty(input logic [DATA_WIDTH-1:0] v);
    int s;
    s = int'($signed(v));
    return (s >>> (DATA_WIDTH - PWM_BITS)) + PWM_PERIOD / 2;
  endfunction

  // Offer one beat and hold it until accepted (bounded); record the expectations.
  task automatic send_beat(input logic [DATA_WIDTH-1:0] re, input logic last,
                           output int waited, output int acc_cyc);
    bit ok;
    bit at_end;
    ok = 1'b0;
    waited = 0;
    acc_cyc = 0;
    s_tdata  = {DATA_WIDTH'($urandom), re};
    s_tvalid = 1'b1;
    s_tlast  = last;
    for (int n = 0; n < BEAT_TIMEOUT; n++) begin
      @(negedge clock);
      if (s_tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (ok) begin
      at_end = (model_beat == FRAME_LEN - 1);
      exp_q.push_back(exp_duty(re));
      fe_q.push_back(last != at_end);
      model_beat = (last || at_end) ? 0 : model_beat + 1;
      acc_cyc = cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: got no s_tready within %0d cycles", BEAT_TIMEOUT);
    end
    @(posedge clock);
    #2;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Wait until every queued sample has been played and playback has stopped.
  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < max_cycles) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0 || mon_active) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d samples still pending expected 0", exp_q.size());
    end
    repeat (4) @(posedge clock);
    #2;
  endtask

  // One frame from an empty idle FIFO, checking the prefill threshold and play entry.
  task automatic prefill_frame(input bit special);
    logic [DATA_WIDTH-1:0] v;
    int w, c;
    for (int i = 0; i < FRAME_LEN; i++) begin
      v = DATA_WIDTH'($urandom);
      if (special && i == 0) v = 16'h7FFF;
      if (special && i == 1) v = 16'h0000;
      if (special && i == 2) v = 16'h8000;
      send_beat(v, (i == FRAME_LEN - 1), w, c);
      if (i == FRAME_LEN - 2) check("prefill_idle_aud_sd", 32'(aud_sd), 32'd0);
    end
    check("play_entry_aud_sd", 32'(aud_sd), 32'd1);
  endtask

  // Monitor: scores each sample's PWM window, underflow and frame_error pulses.
  initial begin : monitor
    int   mon_pos, mon_hi, d, exp_hi;
    bit   last_s, hs_prev;
    logic exp_uf, exp_fe;
    mon_pos = 0;
    mon_hi  = 0;
    hs_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_active = 1'b0;
        hs_prev    = 1'b0;
      end else begin
        exp_uf = 1'b0;
        if (!mon_active) begin
          if (aud_sd) begin
            mon_active = 1'b1;
            mon_pos    = 0;
            mon_hi     = 0;
          end
        end else begin
          mon_pos++;
          // Window of a sample: from 2 cycles after its pop, SAMPLE_DIV cycles long.
          if (mon_pos >= 2) begin
            mon_hi += int'(aud_pwm);
            if (((mon_pos - 2) % SAMPLE_DIV) == SAMPLE_DIV - 1) begin
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_sample: got a played window expected no queued sample");
                mon_active = 1'b0;
              end else begin
                d      = exp_q.pop_front();
                last_s = (exp_q.size() == 0);
                exp_hi = d * (SAMPLE_DIV / PWM_PERIOD);
                // At underflow the pin is already low in the window's final slot.
                if (last_s && d > 0) exp_hi--;
                check("pwm_high_cycles", 32'(mon_hi), 32'(exp_hi));
                check("aud_sd_at_window_end", 32'(aud_sd), 32'(!last_s));
                if (last_s) begin
                  check("aud_pwm_at_underflow", 32'(aud_pwm), 32'd0);
                  exp_uf     = 1'b1;
                  mon_active = 1'b0;
                end
              end
              mon_hi = 0;
            end
          end
        end
        check("underflow", 32'(underflow), 32'(exp_uf));
        exp_fe = 1'b0;
        if (hs_prev && fe_q.size() > 0) exp_fe = fe_q.pop_front();
        check("frame_error", 32'(frame_error), 32'(exp_fe));
        hs_prev = s_tvalid && s_tready;
      end
    end
  end

  initial begin : stimulus
    int w, c, prev_c, first_stall;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_aud_sd", 32'(aud_sd), 32'd0);
    check("rst_aud_pwm", 32'(aud_pwm), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("post_rst_s_tready", 32'(s_tready), 32'd1);
    @(posedge clock);
    #2;

    // Prefill, duty mapping (full scale, zero, negative full scale) and underflow.
    prefill_frame(1'b1);
    wait_drain((FRAME_LEN + 3) * SAMPLE_DIV);

    // Backpressure: 40 beats offered back to back; the last tlast is misplaced.
    first_stall = 0;
    prev_c = 0;
    for (int i = 1; i <= 40; i++) begin
      send_beat(DATA_WIDTH'($urandom), (i % FRAME_LEN == 0) || (i == 40), w, c);
      if (w > 0 && first_stall == 0) first_stall = i;
      if (i >= 35) check("bp_accept_gap", 32'(c - prev_c), 32'(SAMPLE_DIV));
      if (i >= 34) check("bp_refull_s_tready", 32'(s_tready), 32'd0);
      prev_c = c;
    end
    // 16 beats start playback; the first pop coincides with beat 17, so beat 33 fills it.
    check("bp_first_stall_beat", 32'(first_stall), 32'(DEPTH + 2));
    wait_drain(45 * SAMPLE_DIV);

    // Framing: early tlast on beat 10, then 16 beats with tlast missing.
    for (int i = 1; i <= 10; i++) send_beat(DATA_WIDTH'($urandom), (i == 10), w, c);
    for (int i = 1; i <= 16; i++) send_beat(DATA_WIDTH'($urandom), 1'b0, w, c);
    wait_drain(30 * SAMPLE_DIV);

    // Reset in the middle of a PWM period while playing.
    for (int i = 0; i < FRAME_LEN; i++) send_beat(DATA_WIDTH'($urandom), (i == FRAME_LEN - 1), w, c);
    repeat (700) @(posedge clock);
    #3;
    reset = 1'b1;
    exp_q.delete();
    fe_q.delete();
    model_beat = 0;
    #1;
    check("midrst_s_tready", 32'(s_tready), 32'd0);
    check("midrst_aud_sd", 32'(aud_sd), 32'd0);
    check("midrst_aud_pwm", 32'(aud_pwm), 32'd0);
    check("midrst_underflow", 32'(underflow), 32'd0);
    check("midrst_frame_error", 32'(frame_error), 32'd0);
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_release_s_tready", 32'(s_tready), 32'd1);
    @(posedge clock);
    #2;
    prefill_frame(1'b0);
    wait_drain((FRAME_LEN + 3) * SAMPLE_DIV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
